// File: rtl/shift_link_pkg.sv
// Definitions shared by both ends of the parallel-load right-shift serial link.
// Holds the receiver state encoding and the link-wide word width.
package shift_link_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_e;

  localparam int unsigned SHIFT_LINK_WIDTH = 8;

  // Bit 0 of a word travels first on the wire.
  localparam bit SHIFT_LINK_LSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_receiver_if.sv
// Serial input and valid/ready word output of the shift link receiver.
// The master drives the bits and consumes words; the slave is the receiver.
interface shift_receiver_if #(
  parameter int unsigned WIDTH = shift_link_pkg::SHIFT_LINK_WIDTH
);

  logic             start;
  logic             sin;
  logic             sin_valid;
  logic             out_ready;
  logic             clr_overrun;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             busy;
  logic             overrun;

  modport master (
    output start, sin, sin_valid, out_ready, clr_overrun,
    input  data_out, data_valid, busy, overrun
  );

  modport slave (
    input  start, sin, sin_valid, out_ready, clr_overrun,
    output data_out, data_valid, busy, overrun
  );

endinterface

// File: rtl/shift_in_reg.sv
// WIDTH-bit right shift register with MSB entry, synchronous clear and shift enable.
// Clear combined with shift loads the incoming bit as the first bit of a new word.
module shift_in_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             shift_en_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
      if (shift_en_i) q_d[WIDTH-1] = sin_i;
    end else if (shift_en_i) begin
      q_d = {sin_i, q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/shift_receiver.sv
// Serial-to-parallel receiver: assembles WIDTH LSB-first bits into a word held in an
// output register with valid/ready handshake; words with no free slot set sticky overrun.
module shift_receiver
  import shift_link_pkg::*;
#(
  parameter int unsigned WIDTH = SHIFT_LINK_WIDTH
) (
  input logic              clk,
  input logic              reset_n,
  shift_receiver_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic             ovr_q, ovr_d;

  logic [WIDTH-1:0] shreg;
  logic             accept;
  logic             complete;
  logic             slot_free;
  logic [WIDTH-1:0] word;

  // A bit is taken either inside a frame or together with the start that opens one.
  assign accept    = bus.sin_valid && (bus.start || (state_q == RECV));
  assign complete  = (state_q == RECV) && !bus.start && bus.sin_valid &&
                     (cnt_q == CNT_W'(WIDTH - 1));
  assign slot_free = !dvalid_q || bus.out_ready;
  assign word      = {bus.sin, shreg[WIDTH-1:1]};

  shift_in_reg #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk        (clk),
    .rst_n      (reset_n),
    .clr_i      (bus.start),
    .shift_en_i (accept),
    .sin_i      (bus.sin),
    .q_o        (shreg)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RECV;
          cnt_d   = CNT_W'(bus.sin_valid);
        end
      end
      RECV: begin
        if (bus.start) begin
          cnt_d = CNT_W'(bus.sin_valid);
        end else if (complete) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (bus.sin_valid) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    ovr_d    = ovr_q && !bus.clr_overrun;
    if (complete && slot_free) begin
      dout_d   = word;
      dvalid_d = 1'b1;
    end else begin
      if (complete) ovr_d = 1'b1;
      if (dvalid_q && bus.out_ready) dvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign bus.data_out   = dout_q;
  assign bus.data_valid = dvalid_q;
  assign bus.busy       = (state_q == RECV);
  assign bus.overrun    = ovr_q;

endmodule
